enemy_projectile_pool: RTL

Downward-moving enemy missile pool, the counterpart of the player's upward projectile. Holds up to NUM_SLOTS missiles spawned by the enemy controller through a req/ack handshake. Moves active missiles once per frame and collides them against the player. Drives the per-pixel draw flag for the colour mapper and a hit pulse to player/lives logic.

---
 rtl/game_pkg.sv | 24 ++
 rtl/enemy_projectile_slot.sv | 78 +++++++
 rtl/enemy_projectile_pool.sv | 122 ++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared game types and constants: screen geometry, coordinate types,
// per-slot state encoding and default missile geometry.
package game_pkg;

  typedef logic        [9:0]  coord_t;
  typedef logic signed [10:0] scoord_t;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef enum logic {
    IDLE = 1'b0,
    FLY  = 1'b1
  } slot_state_e;

  localparam coord_t MISSILE_SIZE = 10'd3;
  localparam coord_t MISSILE_STEP = 10'd3;

  // Zero-extend both operands so the result is a true signed difference.
  function automatic scoord_t sdiff(input coord_t a, input coord_t b);
    return scoord_t'({1'b0, a}) - scoord_t'({1'b0, b});
  endfunction

endpackage

// File: rtl/enemy_projectile_slot.sv
// One enemy missile slot: IDLE/FLY state, position, player-hit and
// bottom-exit tests, and the circular pixel test for the colour mapper.
module enemy_projectile_slot
  import game_pkg::*;
#(
  parameter coord_t STEP        = MISSILE_STEP,
  parameter coord_t SIZE        = MISSILE_SIZE,
  parameter coord_t Y_MAX       = coord_t'(SCREEN_H - 1),
  parameter coord_t PLAYER_HALF = 10'd10
) (
  input  logic   Clk,
  input  logic   Reset,
  input  logic   i_frame_tick,
  input  logic   i_load,
  input  coord_t i_load_x,
  input  coord_t i_load_y,
  input  coord_t i_player_x,
  input  coord_t i_player_y,
  input  coord_t i_draw_x,
  input  coord_t i_draw_y,
  output logic   o_active,
  output logic   o_hit_now,
  output logic   o_exit_now,
  output logic   o_pix_hit
);

  slot_state_e r_state;
  coord_t      r_x, r_y;

  scoord_t w_px, w_py, w_apx, w_apy, w_dx, w_dy;
  logic signed [21:0] w_dist2, w_size2;

  assign w_px  = sdiff(r_x, i_player_x);
  assign w_py  = sdiff(r_y, i_player_y);
  assign w_apx = (w_px < 0) ? -w_px : w_px;
  assign w_apy = (w_py < 0) ? -w_py : w_py;

  assign o_active   = (r_state == FLY);
  assign o_hit_now  = o_active && (w_apx <= scoord_t'({1'b0, PLAYER_HALF}))
                               && (w_apy <= scoord_t'({1'b0, PLAYER_HALF}));
  assign o_exit_now = o_active && !o_hit_now && (r_y >= (Y_MAX - SIZE));

  // Largest |d| is 1023, so 2*d^2 still fits in 22-bit signed.
  assign w_dx      = sdiff(i_draw_x, r_x);
  assign w_dy      = sdiff(i_draw_y, r_y);
  assign w_dist2   = (22'(w_dx) * 22'(w_dx)) + (22'(w_dy) * 22'(w_dy));
  assign w_size2   = 22'(SIZE) * 22'(SIZE);
  assign o_pix_hit = o_active && (w_dist2 <= w_size2);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // slot sees the same pre-tick values regardless of evaluation order.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= IDLE;
      r_x     <= '0;
      r_y     <= '0;
    end else if (i_frame_tick) begin
      case (r_state)
        IDLE: if (i_load) begin
          r_state <= FLY;
          r_x     <= i_load_x;
          r_y     <= i_load_y;
        end
        FLY: if (o_hit_now) begin
          r_state <= IDLE;
          r_x     <= '0;
          r_y     <= '0;
        end else if (o_exit_now) begin
          r_state <= IDLE;
        end else begin
          r_y <= r_y + STEP;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/enemy_projectile_pool.sv
// Enemy missile pool: frame edge detect, lowest-free-slot allocator, spawn
// cooldown and output reductions. Define ENEMY_PROJ_JITTER_EN to add an
// LFSR-based random extension (0..15 frames) to the spawn cooldown.
module enemy_projectile_pool
  import game_pkg::*;
#(
  parameter int     NUM_SLOTS   = 4,
  parameter coord_t STEP        = MISSILE_STEP,
  parameter coord_t SIZE        = MISSILE_SIZE,
  parameter coord_t Y_MAX       = coord_t'(SCREEN_H - 1),
  parameter coord_t PLAYER_HALF = 10'd10,
  parameter logic [7:0] FIRE_PERIOD = 8'd45
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       fire_req,
  input  coord_t     fire_x,
  input  coord_t     fire_y,
  output logic       fire_ack,
  input  coord_t     player_x_pos,
  input  coord_t     player_y_pos,
  input  coord_t     DrawX,
  input  coord_t     DrawY,
  output logic       is_enemy_missile,
  output logic       player_hit,
  output logic [3:0] active_count
);

  logic r_frame_clk_d, r_frame_tick;
  logic [7:0] r_cooldown;

  logic [NUM_SLOTS-1:0] w_active, w_hit, w_exit, w_pix, w_free_sel, w_next_active;
  logic       w_found, w_spawn;
  logic [7:0] w_cd_dec, w_reload;
  logic [3:0] w_next_count;

  // Lowest-index IDLE slot; states are pre-tick, so slots freed on this
  // tick are not candidates.
  // NOTE: every always_comb output gets a default first so no latch forms.
  always_comb begin
    w_free_sel = '0;
    w_found    = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!w_active[i] && !w_found) begin
        w_free_sel[i] = 1'b1;
        w_found       = 1'b1;
      end
    end
  end

  // The cooldown counts down first and gates on its new value, so spawns
  // are spaced exactly by the reload value in frames.
  assign w_cd_dec = (r_cooldown == 8'd0) ? 8'd0 : r_cooldown - 8'd1;
  assign w_spawn  = fire_req && w_found && (w_cd_dec == 8'd0);

  always_comb begin
    w_next_count = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      w_next_active[i] = (w_active[i] && !w_hit[i] && !w_exit[i])
                       || (w_free_sel[i] && w_spawn);
      w_next_count     = w_next_count + 4'(w_next_active[i]);
    end
  end

`ifdef ENEMY_PROJ_JITTER_EN
  logic [7:0] r_lfsr;

  always_ff @(posedge Clk) begin
    if (Reset) r_lfsr <= 8'hA5;
    else if (r_frame_tick) r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  end

  assign w_reload = FIRE_PERIOD + {4'b0, r_lfsr[3:0]};
`else
  assign w_reload = FIRE_PERIOD;
`endif

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    enemy_projectile_slot #(
      .STEP(STEP), .SIZE(SIZE), .Y_MAX(Y_MAX), .PLAYER_HALF(PLAYER_HALF)
    ) u_slot (
      .Clk          (Clk),
      .Reset        (Reset),
      .i_frame_tick (r_frame_tick),
      .i_load       (w_free_sel[g] && w_spawn),
      .i_load_x     (fire_x),
      .i_load_y     (fire_y),
      .i_player_x   (player_x_pos),
      .i_player_y   (player_y_pos),
      .i_draw_x     (DrawX),
      .i_draw_y     (DrawY),
      .o_active     (w_active[g]),
      .o_hit_now    (w_hit[g]),
      .o_exit_now   (w_exit[g]),
      .o_pix_hit    (w_pix[g])
    );
  end

  assign is_enemy_missile = |w_pix;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_frame_clk_d <= 1'b0;
      r_frame_tick  <= 1'b0;
      r_cooldown    <= 8'd0;
      fire_ack      <= 1'b0;
      player_hit    <= 1'b0;
      active_count  <= 4'd0;
    end else begin
      r_frame_clk_d <= frame_clk;
      r_frame_tick  <= frame_clk && !r_frame_clk_d;
      fire_ack      <= r_frame_tick && w_spawn;
      player_hit    <= r_frame_tick && (|w_hit);
      if (r_frame_tick) begin
        r_cooldown   <= w_spawn ? w_reload : w_cd_dec;
        active_count <= w_next_count;
      end
    end
  end

endmodule
